fir_moving_avg: RTL and testbench

N-tap moving-average FIR stage for the Lab 5 audio path, left and right channels instantiated separately. Sits directly downstream of the enabled input register stage: it consumes that stage's registered 24-bit sample together with the same sample-valid strobe, and produces a filtered sample for the codec write side. Each accepted sample is pre-scaled by 1/N and stored in an N-entry circular buffer. A running accumulator adds the newest scaled sample and subtracts the oldest, so the output updates once per accepted sample.

---
 rtl/fir_moving_avg.sv | 67 ++++++
 tb/tb_fir_moving_avg.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/fir_moving_avg.sv
// N-tap moving-average FIR: each accepted sample is pre-scaled by 1/N, stored in a
// circular buffer, and folded into a running sum that adds the newest and drops the oldest.
module fir_moving_avg #(
    parameter int WIDTH     = 24,
    parameter int LOG2_TAPS = 3
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    en,
    input  logic                    clear,
    input  logic signed [WIDTH-1:0] d_in,
    output logic signed [WIDTH-1:0] d_out,
    output logic                    valid_out,
    output logic                    primed
);

    localparam int N = 1 << LOG2_TAPS;
    localparam logic [LOG2_TAPS:0] CNT_FULL = (LOG2_TAPS + 1)'(N);

    logic signed [WIDTH-1:0] taps [N];
    logic [LOG2_TAPS-1:0]    wr_ptr;
    logic [LOG2_TAPS:0]      cnt;
    logic [LOG2_TAPS:0]      cnt_next;
    logic signed [WIDTH-1:0] acc;
    logic signed [WIDTH-1:0] acc_next;
    logic signed [WIDTH-1:0] scaled;

    // Sum of N pre-scaled samples always fits in WIDTH bits, so the accumulator
    // needs no guard bits and no saturation.
    always_comb begin
        scaled   = d_in >>> LOG2_TAPS;
        acc_next = acc + scaled - taps[wr_ptr];
        cnt_next = (cnt == CNT_FULL) ? cnt : cnt + 1'b1;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < N; i++) taps[i] <= '0;
            wr_ptr    <= '0;
            cnt       <= '0;
            acc       <= '0;
            d_out     <= '0;
            valid_out <= 1'b0;
            primed    <= 1'b0;
        end else if (clear) begin
            // Flush wins over a coincident strobe; that sample is dropped.
            for (int i = 0; i < N; i++) taps[i] <= '0;
            wr_ptr    <= '0;
            cnt       <= '0;
            acc       <= '0;
            d_out     <= '0;
            valid_out <= 1'b0;
            primed    <= 1'b0;
        end else if (en) begin
            taps[wr_ptr] <= scaled;
            wr_ptr       <= wr_ptr + 1'b1;
            cnt          <= cnt_next;
            acc          <= acc_next;
            d_out        <= acc_next;
            valid_out    <= 1'b1;
            primed       <= (cnt_next == CNT_FULL);
        end else begin
            valid_out <= 1'b0;
        end
    end

endmodule

// File: tb/tb_fir_moving_avg.sv
// Moving-average FIR bench: window-sum model over accepted samples, per-cycle compare,
// plus directed literal expectations from the test plan.
module tb_fir_moving_avg;

    localparam int W = 24;
    localparam int L = 3;
    localparam int N = 1 << L;

    logic                clk = 1'b0;
    logic                reset = 1'b0;
    logic                en = 1'b0;
    logic                clear = 1'b0;
    logic signed [W-1:0] d_in = '0;
    logic signed [W-1:0] d_out;
    logic                valid_out;
    logic                primed;

    int errors = 0;
    int checks = 0;

    int hist[$];
    int exp_dout = 0;
    int exp_cnt = 0;
    bit exp_valid = 1'b0;
    bit exp_primed = 1'b0;
    bit run_cmp = 1'b0;

    fir_moving_avg #(.WIDTH(W), .LOG2_TAPS(L)) dut (
        .clk(clk), .reset(reset), .en(en), .clear(clear), .d_in(d_in),
        .d_out(d_out), .valid_out(valid_out), .primed(primed)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Floor division by N, i.e. rounding toward minus infinity.
    function automatic int scale(input int d);
        if (d >= 0) return d / N;
        return -((-d + N - 1) / N);
    endfunction

    function automatic int window_sum();
        longint s = 0;
        foreach (hist[i]) s += hist[i];
        return int'(s);
    endfunction

    task automatic model_reset();
        hist.delete();
        exp_dout   = 0;
        exp_cnt    = 0;
        exp_valid  = 1'b0;
        exp_primed = 1'b0;
    endtask

    task automatic model_clock(input bit e, input bit c, input int d);
        if (!reset) begin
            model_reset();
        end else if (c) begin
            model_reset();
        end else if (e) begin
            hist.push_back(scale(d));
            if (hist.size() > N) void'(hist.pop_front());
            exp_dout  = window_sum();
            exp_valid = 1'b1;
            if (exp_cnt < N) exp_cnt++;
            exp_primed = (exp_cnt == N);
        end else begin
            exp_valid = 1'b0;
        end
    endtask

    // One clock: drive on the falling edge, advance the model on the rising edge.
    task automatic cyc(input bit e, input bit c, input int d);
        @(negedge clk);
        en    = e;
        clear = c;
        d_in  = d[W-1:0];
        @(posedge clk);
        model_clock(e, c, d);
        #1;
    endtask

    always @(negedge clk) begin
        if (run_cmp && reset) begin
            chk("cmp_d_out", int'(d_out), exp_dout);
            chk("cmp_valid_out", int'(valid_out), int'(exp_valid));
            chk("cmp_primed", int'(primed), int'(exp_primed));
        end
    end

    initial begin
        logic signed [W-1:0] r;
        int gap;

        repeat (2) @(posedge clk);
        #1;
        chk("reset_d_out", int'(d_out), 0);
        chk("reset_valid", int'(valid_out), 0);
        chk("reset_primed", int'(primed), 0);
        @(negedge clk);
        reset   = 1'b1;
        run_cmp = 1'b1;

        // Step up, one more full-scale sample, then step down.
        for (int i = 1; i <= 8; i++) begin
            cyc(1, 0, 800);
            chk("step_up", int'(d_out), 100 * i);
            chk("model_step_up", exp_dout, 100 * i);
            chk("step_primed", int'(primed), (i == 8) ? 1 : 0);
        end
        cyc(1, 0, 800);
        chk("step_ninth", int'(d_out), 800);
        for (int i = 1; i <= 8; i++) begin
            cyc(1, 0, 0);
            chk("step_down", int'(d_out), 800 - 100 * i);
        end

        // Negative values and floor rounding.
        for (int i = 0; i < 8; i++) cyc(1, 0, -8);
        chk("neg8", int'(d_out), -8);
        for (int i = 0; i < 8; i++) cyc(1, 0, -1);
        chk("neg1", int'(d_out), -8);
        chk("model_neg1", exp_dout, -8);
        for (int i = 0; i < 8; i++) cyc(1, 0, 7);
        chk("pos7", int'(d_out), 0);

        // Full-scale extremes.
        for (int i = 0; i < 8; i++) cyc(1, 0, 'h7FFFFF);
        chk("max", int'(d_out), 'h7FFFF8);
        chk("model_max", exp_dout, 'h7FFFF8);
        for (int i = 0; i < 8; i++) cyc(1, 0, -8388608);
        chk("min", int'(d_out), -8388608);

        // Gapped strobe from a clean state.
        cyc(0, 1, 0);
        chk("clear_d_out", int'(d_out), 0);
        cyc(1, 0, 800);
        chk("gap_first", int'(d_out), 100);
        for (int i = 0; i < 3; i++) begin
            cyc(0, 0, 0);
            chk("gap_hold", int'(d_out), 100);
            chk("gap_valid", int'(valid_out), 0);
        end
        cyc(1, 0, 1600);
        chk("gap_second", int'(d_out), 300);

        // Random gapped samples against the window-sum model.
        for (int k = 0; k < 20; k++) begin
            r = W'($urandom);
            cyc(1, 0, int'(r));
            gap = $urandom_range(0, 3);
            for (int g = 0; g < gap; g++) cyc(0, 0, int'(W'($urandom)));
        end
        for (int k = 0; k < 40; k++) begin
            r = W'($urandom);
            cyc(1, 0, int'(r));
        end

        // Clear colliding with a strobe.
        cyc(0, 1, 0);
        for (int i = 0; i < 8; i++) cyc(1, 0, 800);
        chk("prime_before_clear", int'(primed), 1);
        cyc(1, 1, 1600);
        chk("coll_d_out", int'(d_out), 0);
        chk("coll_primed", int'(primed), 0);
        chk("coll_valid", int'(valid_out), 0);
        cyc(1, 0, 800);
        chk("after_clear", int'(d_out), 100);

        // Asynchronous reset between edges, mid-stream.
        cyc(0, 1, 0);
        for (int i = 0; i < 5; i++) cyc(1, 0, 800);
        chk("pre_reset", int'(d_out), 500);
        #2;
        en    = 1'b0;
        reset = 1'b0;
        #1;
        chk("async_d_out", int'(d_out), 0);
        chk("async_valid", int'(valid_out), 0);
        chk("async_primed", int'(primed), 0);
        model_reset();
        cyc(0, 0, 0);
        reset = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            cyc(1, 0, 800);
            chk("post_reset", int'(d_out), 100 * i);
            chk("post_reset_primed", int'(primed), (i == 8) ? 1 : 0);
        end
        cyc(0, 0, 0);

        run_cmp = 1'b0;
        @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
